// File: rtl/axi_lite_mult_engine_pkg.sv
// Shared definitions for the AXI4-Lite multiplier engine: register word
// offsets (address bits [4:2]), CTRL/STATUS bit positions, response code,
// FSM state encoding and a byte-strobe merge helper.
package axi_lite_mult_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_OPA    = 3'd2;
  localparam logic [2:0] REG_OPB    = 3'd3;
  localparam logic [2:0] REG_RES_LO = 3'd4;
  localparam logic [2:0] REG_RES_HI = 3'd5;
  localparam logic [2:0] REG_CONFIG = 3'd6;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_SIGNED = 1;
  localparam int unsigned CTRL_AUTO   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_mult_engine_if.sv
// AXI4-Lite bus bundle for the multiplier engine.
// master modport: drives address/data/valid and response-ready signals.
// slave modport : drives ready, response and read-data signals.
interface axi_lite_mult_engine_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_mult_engine_mult_pipe.sv
// Pipelined signed/unsigned multiplier.
// Ports: clk, rst_n (async active-low), load (capture operands), a/b
// (OP_WIDTH operands), is_signed, product (64-bit, sign/zero extended).
// Latency: product reflects the operands captured by load exactly
// PIPE_STAGES-1 cycles after the load edge, so the caller samples it on
// edge load+PIPE_STAGES.
module mult_pipe
  import axi_lite_mult_pkg::*;
#(
  parameter int unsigned OP_WIDTH    = 32,
  parameter int unsigned PIPE_STAGES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [OP_WIDTH-1:0] a,
  input  logic [OP_WIDTH-1:0] b,
  input  logic                is_signed,
  output logic [63:0]         product
);

  logic [OP_WIDTH-1:0] a_q;
  logic [OP_WIDTH-1:0] b_q;
  logic                sgn_q;
  logic [63:0]         a_ext;
  logic [63:0]         b_ext;
  logic [63:0]         prod;

  // First stage doubles as the operand latch: it only moves on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else if (load) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= is_signed;
    end
  end

  // Extending both operands to 64 bits and truncating the product gives
  // the correctly extended 2*OP_WIDTH result for either signedness.
  always_comb begin
    a_ext = {{(64-OP_WIDTH){sgn_q & a_q[OP_WIDTH-1]}}, a_q};
    b_ext = {{(64-OP_WIDTH){sgn_q & b_q[OP_WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  generate
    if (PIPE_STAGES == 1) begin : g_comb
      assign product = prod;
    end else begin : g_pipe
      logic [63:0] stg_q [PIPE_STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < PIPE_STAGES-1; i++) stg_q[i] <= '0;
        end else begin
          stg_q[0] <= prod;
          for (int unsigned i = 1; i < PIPE_STAGES-1; i++) stg_q[i] <= stg_q[i-1];
        end
      end

      assign product = stg_q[PIPE_STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/axi_lite_mult_engine.sv
// AXI4-Lite slave multiplier peripheral.
// Ports: S_AXI_ACLK (clock), S_AXI_ARESETN (async active-low reset),
// s_axi (AXI4-Lite slave bundle), irq (registered DONE & IRQ_EN).
// Registers: CTRL, STATUS, OPA, OPB, RES_LO, RES_HI, CONFIG at 0x00..0x18.
module axi_lite_mult_engine
  import axi_lite_mult_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned OP_WIDTH           = 32,
  parameter int unsigned PIPE_STAGES        = 3
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  axi_lite_mult_engine_if.slave   s_axi,
  output logic                    irq
);

  // AXI channel state
  logic                          wa_rdy_q;
  logic                          bvalid_q;
  logic                          ar_rdy_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  // Register file / FSM
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        irq_en_q;
  logic        auto_q;
  logic        sgn_q;
  logic        done_q;
  logic        irq_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [63:0] res_q;

  // Combinational helpers
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_w;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_w;
  logic [2:0]                    wr_idx;
  logic [2:0]                    rd_idx;
  logic                          wr_fire;
  logic                          rd_fire;
  logic [31:0]                   ctrl_cur;
  logic [31:0]                   ctrl_wr;
  logic [31:0]                   opa_wr;
  logic [31:0]                   opb_wr;
  logic [31:0]                   trig_b;
  logic                          trig_sgn;
  logic                          trigger;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;
  logic [63:0]                   product;
  logic                          unused_bits;

  assign awaddr_w = s_axi.awaddr;
  assign araddr_w = s_axi.araddr;
  assign wr_idx   = awaddr_w[4:2];
  assign rd_idx   = araddr_w[4:2];
  assign wr_fire  = wa_rdy_q & s_axi.awvalid & s_axi.wvalid;
  assign rd_fire  = ar_rdy_q & s_axi.arvalid;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, awaddr_w[1:0], araddr_w[1:0]};

  assign s_axi.awready = wa_rdy_q;
  assign s_axi.wready  = wa_rdy_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = ar_rdy_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.rdata   = rdata_q;
  assign irq           = irq_q;

  always_comb begin
    ctrl_cur = {28'b0, irq_en_q, auto_q, sgn_q, 1'b0};
    ctrl_wr  = apply_wstrb(ctrl_cur, s_axi.wdata, s_axi.wstrb);
    opa_wr   = apply_wstrb(opa_q, s_axi.wdata, s_axi.wstrb);
    opb_wr   = apply_wstrb(opb_q, s_axi.wdata, s_axi.wstrb);
    // The triggering write itself may carry the new OPB (AUTO) or the new
    // SIGNED bit (CTRL), so the operands fed to the pipe are the merged ones.
    trig_b   = (wr_idx == REG_OPB)  ? opb_wr : opb_q;
    trig_sgn = (wr_idx == REG_CTRL) ? ctrl_wr[CTRL_SIGNED] : sgn_q;
    trigger  = (state_q == ST_IDLE) && wr_fire &&
               (((wr_idx == REG_CTRL) && ctrl_wr[CTRL_START]) ||
                ((wr_idx == REG_OPB) && auto_q));
  end

  always_comb begin
    rd_val = '0;
    unique case (rd_idx)
      REG_CTRL:   rd_val = ctrl_cur;
      REG_STATUS: rd_val = {30'b0, done_q, (state_q == ST_RUN)};
      REG_OPA:    rd_val = opa_q;
      REG_OPB:    rd_val = opb_q;
      REG_RES_LO: rd_val = res_q[31:0];
      REG_RES_HI: rd_val = res_q[63:32];
      REG_CONFIG: rd_val = {16'b0, 8'(PIPE_STAGES), 8'(OP_WIDTH)};
      default:    rd_val = '0;
    endcase
  end

  // AXI handshakes: AW/W ready pulse together, one outstanding per channel.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wa_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wa_rdy_q <= !wa_rdy_q && s_axi.awvalid && s_axi.wvalid && !bvalid_q;
      if (wr_fire)                     bvalid_q <= 1'b1;
      else if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;

      ar_rdy_q <= !ar_rdy_q && s_axi.arvalid && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register file and FSM. Completion is written after the W1C clear so
  // a same-cycle DONE set takes priority.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      auto_q   <= 1'b0;
      sgn_q    <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
    end else begin
      if (wr_fire) begin
        case (wr_idx)
          REG_CTRL: begin
            irq_en_q <= ctrl_wr[CTRL_IRQ_EN];
            auto_q   <= ctrl_wr[CTRL_AUTO];
            sgn_q    <= ctrl_wr[CTRL_SIGNED];
          end
          REG_STATUS: if (s_axi.wstrb[0] && s_axi.wdata[STAT_DONE]) done_q <= 1'b0;
          REG_OPA:    opa_q <= opa_wr;
          REG_OPB:    opb_q <= opb_wr;
          default: ;
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'(PIPE_STAGES);
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_q == 4'd1) begin
            state_q <= ST_IDLE;
            res_q   <= product;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase

      irq_q <= done_q & irq_en_q;
    end
  end

  mult_pipe #(
    .OP_WIDTH    (OP_WIDTH),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_mult_pipe (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .load      (trigger),
    .a         (opa_q[OP_WIDTH-1:0]),
    .b         (trig_b[OP_WIDTH-1:0]),
    .is_signed (trig_sgn),
    .product   (product)
  );

endmodule

// File: tb/tb_axi_lite_mult_engine.sv
// Directed self-checking bench for axi_lite_mult_engine (default params).
module tb_axi_lite_mult_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq;
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_mult_engine_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  axi_lite_mult_engine #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .OP_WIDTH           (32),
    .PIPE_STAGES        (3)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .irq           (irq)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit hold_b);
    int n;
    int held;
    @(negedge clk);
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = !hold_b;
    n = 0;
    while (!bus.awready && n < 20) begin @(negedge clk); n++; end
    if (!bus.awready) check_eq("awready timeout", bus.awready, 1);
    check_eq("wready with awready", bus.wready, bus.awready);
    @(posedge clk); #1;
    acc_cyc     = cyc;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.bvalid) check_eq("bvalid timeout", bus.bvalid, 1);
    if (hold_b) begin
      held = 0;
      repeat (5) begin @(negedge clk); if (bus.bvalid) held++; end
      check_eq("bvalid held", held, 5);
      check_eq("bresp okay", bus.bresp, 0);
      bus.bready = 1'b1;
    end
    @(posedge clk); #1;
    if (hold_b) check_eq("bvalid drop", bus.bvalid, 0);
  endtask

  task automatic read_check(input logic [4:0] addr, input logic [31:0] exp,
                            input string tag, input bit hold_r);
    int n;
    int stable;
    logic [31:0] data;
    @(negedge clk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = !hold_r;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    if (!bus.arready) check_eq("arready timeout", bus.arready, 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.rvalid) check_eq("rvalid timeout", bus.rvalid, 1);
    data = bus.rdata;
    check_eq(tag, data, exp);
    if (hold_r) begin
      stable = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.rvalid && bus.rdata === exp) stable++;
      end
      check_eq("rdata held", stable, 5);
      bus.rready = 1'b1;
    end
    @(posedge clk); #1;
    if (hold_r) check_eq("rvalid drop", bus.rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    logic [31:0] rst_exp [8];
    int unsigned t0;
    int unsigned t1;
    int unsigned rise;
    int n;

    rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h320, 32'h0};
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset handshake outs",
             {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, irq, bus.bresp, bus.rresp}, 0);
    check_eq("reset rdata", bus.rdata, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) read_check(5'(i * 4), rst_exp[i], $sformatf("reset reg 0x%0h", i * 4), 1'b0);
    check_eq("reset irq", irq, 0);

    // Unsigned: 0xFFFFFFFF * 2
    axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, 1'b0);
    axi_write(5'h0C, 32'h2, 4'hF, 1'b0);
    axi_write(5'h00, 32'h1, 4'hF, 1'b0);
    read_check(5'h04, 32'h1, "unsigned status at completion edge", 1'b0);
    read_check(5'h04, 32'h2, "unsigned status done", 1'b0);
    read_check(5'h14, 32'h1, "unsigned res_hi", 1'b0);
    read_check(5'h10, 32'hFFFF_FFFE, "unsigned res_lo", 1'b0);
    read_check(5'h00, 32'h0, "ctrl start reads 0", 1'b0);

    // Signed: -3 * 7
    axi_write(5'h08, 32'hFFFF_FFFD, 4'hF, 1'b0);
    axi_write(5'h0C, 32'h7, 4'hF, 1'b0);
    axi_write(5'h00, 32'h3, 4'hF, 1'b0);
    read_check(5'h04, 32'h1, "signed status busy", 1'b0);
    read_check(5'h14, 32'hFFFF_FFFF, "signed res_hi", 1'b0);
    read_check(5'h10, 32'hFFFF_FFEB, "signed res_lo", 1'b0);
    read_check(5'h00, 32'h2, "ctrl signed kept", 1'b0);

    // AUTO + IRQ
    axi_write(5'h04, 32'h2, 4'hF, 1'b0);
    read_check(5'h04, 32'h0, "done w1c", 1'b0);
    axi_write(5'h00, 32'hC, 4'hF, 1'b0);
    axi_write(5'h08, 32'h10, 4'hF, 1'b0);
    check_eq("irq low before auto", irq, 0);
    axi_write(5'h0C, 32'h10, 4'hF, 1'b0);
    t0 = acc_cyc;
    n = 0;
    while (!irq && n < 20) begin @(negedge clk); n++; end
    rise = cyc;
    if (!irq) check_eq("irq timeout", irq, 1);
    check_eq("irq latency", 64'(rise - t0), 4);
    read_check(5'h10, 32'h100, "auto res_lo", 1'b0);
    check_eq("irq held", irq, 1);
    axi_write(5'h04, 32'h2, 4'hF, 1'b0);
    check_eq("irq cleared", irq, 0);
    read_check(5'h04, 32'h0, "auto status cleared", 1'b0);

    // Busy protection: AUTO trigger arriving on the completion edge is ignored
    axi_write(5'h00, 32'h4, 4'hF, 1'b0);
    axi_write(5'h08, 32'h7, 4'hF, 1'b0);
    axi_write(5'h0C, 32'h6, 4'hF, 1'b0);
    t0 = acc_cyc;
    axi_write(5'h0C, 32'h100, 4'hF, 1'b0);
    t1 = acc_cyc;
    check_eq("busy write window", 64'(t1 - t0), 3);
    read_check(5'h04, 32'h2, "busy status", 1'b0);
    read_check(5'h10, 32'h2A, "busy res_lo original", 1'b0);
    read_check(5'h0C, 32'h100, "busy opb accepted", 1'b0);

    // WSTRB and held responses
    axi_write(5'h08, 32'h0, 4'hF, 1'b0);
    axi_write(5'h08, 32'hAABB_CCDD, 4'h3, 1'b0);
    read_check(5'h08, 32'h0000_CCDD, "wstrb opa", 1'b0);
    axi_write(5'h0C, 32'h1234_5678, 4'hF, 1'b1);
    read_check(5'h0C, 32'h1234_5678, "held read opb", 1'b1);

    // Reset mid-RUN
    axi_write(5'h08, 32'h3, 4'hF, 1'b0);
    axi_write(5'h0C, 32'h4, 4'hF, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrun reset outs", {bus.awready, bus.bvalid, bus.arready, bus.rvalid, irq}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    read_check(5'h04, 32'h0, "midrun status", 1'b0);
    read_check(5'h10, 32'h0, "midrun res_lo", 1'b0);
    read_check(5'h00, 32'h0, "midrun ctrl", 1'b0);
    read_check(5'h08, 32'h0, "midrun opa", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_mult_engine.md
# axi_lite_mult_engine

AXI4-Lite slave multiplier peripheral: parametrised successor to the single-register multiplier IP. Provides software-visible operand, control, status and 64-bit result registers around a pipelined signed/unsigned multiplier with busy/done tracking, auto-start mode and a level interrupt. Sits behind the AXI4-Lite interconnect, driven by the processor or by the AXI4-Lite master BFM in simulation.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; register offsets use bits [4:2].
- OP_WIDTH, 32: operand width, 2..32; operands are the low OP_WIDTH bits of OPA/OPB.
- PIPE_STAGES, 3: multiplier latency in cycles, 1..8.
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY, S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite slave ports, widths per parameters; AWPROT/ARPROT are ignored.
- irq  out  1  level interrupt = DONE & IRQ_EN, registered.

## Operation
- Register map (byte offset): 0x00 CTRL RW {IRQ_EN[3], AUTO[2], SIGNED[1], START[0]}; 0x04 STATUS {DONE[1] W1C, BUSY[0] RO}; 0x08 OPA RW; 0x0C OPB RW; 0x10 RES_LO RO; 0x14 RES_HI RO; 0x18 CONFIG RO {PIPE_STAGES[15:8], OP_WIDTH[7:0]}; 0x1C reads 0.
- All responses OKAY; writes to RO fields ignored; WSTRB honoured per byte on RW registers.
- START is write-1-to-trigger, always reads 0. AUTO=1: an accepted write to OPB also triggers.
- Trigger while BUSY=1 is ignored (no queueing).
- On trigger: OPA/OPB low OP_WIDTH bits and SIGNED latched; BUSY set; DONE cleared.
- Product is 2*OP_WIDTH bits, sign-extended (SIGNED=1) or zero-extended to 64 bits, written to RES_HI:RES_LO only at completion; BUSY cleared, DONE set in the same cycle.
- OPA/OPB/CTRL writes during BUSY are accepted but do not affect the running operation.
- FSM: IDLE -(trigger)-> RUN (down-counter loaded with PIPE_STAGES) -(counter reaches 1)-> IDLE with completion.
- DONE W1C and completion in same cycle: set wins.
- CTRL write with START=1 and new SIGNED: the new SIGNED value is used.

## Timing
- Reset values: all AXI READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, irq 0, all registers 0, FSM IDLE.
- Write: accepted when AWVALID & WVALID both high and BVALID low; AWREADY and WREADY pulse together for exactly one cycle; register updated that edge; BVALID asserted next cycle, held until BREADY.
- Read: ARREADY pulses one cycle when ARVALID & !RVALID; RDATA/RVALID next cycle, held stable until RREADY.
- One outstanding transaction per channel; read and write may proceed concurrently.
- Trigger accepted at edge t: BUSY reads 1 from t+1; completion at edge t+PIPE_STAGES; irq high from t+PIPE_STAGES+1.
- Read of STATUS in completion cycle returns pre-completion value.
- Reset asserted mid-operation: all state cleared immediately, result discarded, in-flight AXI response dropped.

## Structure
- Package axi_lite_mult_pkg: register offsets, CTRL/STATUS bit indices, RESP_OKAY, FSM state encoding.
- Sub-module mult_pipe (OP_WIDTH, PIPE_STAGES): signed/unsigned multiplier with PIPE_STAGES register stages; top holds AXI logic, register file, FSM.

## Test plan
- Reset: after ARESETN release, read all offsets -> 0x0 except CONFIG = 0x0320 (defaults); irq 0.
- Unsigned: OPA=0xFFFFFFFF, OPB=0x2, CTRL=0x1 -> BUSY for 3 cycles, DONE=1, RES_HI=0x1, RES_LO=0xFFFFFFFE.
- Signed: OPA=0xFFFFFFFD (-3), OPB=0x7, CTRL=0x3 -> RES_HI=0xFFFFFFFF, RES_LO=0xFFFFFFEB.
- AUTO+IRQ: CTRL=0xC, OPA=0x10, write OPB=0x10 -> irq rises PIPE_STAGES+1 cycles later, RES_LO=0x100; write STATUS=0x2 -> DONE 0, irq 0.
- Busy protection: trigger, rewrite OPA=0x5 and START during BUSY -> result uses original operands, only one completion.
- WSTRB/handshake: write OPA=0xAABBCCDD with WSTRB=0x3 onto 0 -> reads 0x0000CCDD; BREADY/RREADY held low 5 cycles -> BVALID/RVALID and RDATA stable; reset mid-RUN -> BUSY 0, RES 0.
